// File: rtl/super_pkg.sv
// Shared types for the 64-bit fetch request path.
// Slot record and fetch granularity.
package super_pkg;

  localparam int unsigned FETCH_BYTES = 8;

  typedef struct packed {
    logic valid;
    logic discard;
    logic align64;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_req_tracker.sv
// In-order queue of outstanding fetch slots.
// Head is always entry 0; pops shift the queue down.
module fetch_req_tracker
  import super_pkg::*;
#(
  parameter int NUM_REQS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc_i,
  input  fetch_slot_t                   alloc_slot_i,
  input  logic                          pop_i,
  input  logic                          discard_all_i,
  output fetch_slot_t                   head_o,
  output logic [$clog2(NUM_REQS+1)-1:0] count_o
);

  localparam int CW = $clog2(NUM_REQS + 1);

  fetch_slot_t [NUM_REQS-1:0] slots_q, slots_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] base;

  always_comb begin
    slots_d = slots_q;
    base    = count_q;
    if (pop_i) begin
      for (int i = 0; i < NUM_REQS - 1; i++) begin
        slots_d[i] = slots_q[i+1];
      end
      slots_d[NUM_REQS-1] = '0;
      base = count_q - 1'b1;
    end
    if (alloc_i) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (base == CW'(i)) begin
          slots_d[i] = alloc_slot_i;
        end
      end
    end
    // a slot allocated this cycle is covered too
    if (discard_all_i) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (slots_d[i].valid) begin
          slots_d[i].discard = 1'b1;
        end
      end
    end
    count_d = base + CW'(alloc_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q <= '0;
      count_q <= '0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
    end
  end

  assign head_o  = slots_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_req64.sv
// Request engine of the 64-bit instruction fetch path.
// Issues bus reads, tracks them, forwards responses to the FIFO.
module fetch_req64
  import super_pkg::*;
#(
  parameter int NUM_REQS       = 2,
  parameter bit UnalignedFetch = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fetch_en_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [63:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                fifo_align64_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [63:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                busy_o
);

  localparam int CW = $clog2(NUM_REQS + 1);
  localparam int SW = CW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        align_q, align_d;
  logic        err_halt_q, err_halt_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        pend_align_q, pend_align_d;

  fetch_slot_t    head;
  fetch_slot_t    alloc_slot;
  logic [CW-1:0]  count;
  logic           gnt;
  logic           pop;
  logic           fwd;
  logic [31:0]    tgt_addr;
  logic           tgt_align;
  logic [SW-1:0]  busy_cnt;
  logic [SW-1:0]  cnt_nxt;
  logic           issue_ok;

  assign instr_req_o  = (state_q == REQ);
  assign instr_addr_o = addr_q;
  assign gnt          = instr_req_o & instr_gnt_i;
  assign pop          = instr_rvalid_i & head.valid;
  assign fwd          = pop & ~head.discard & ~branch_i;

  assign fifo_clear_o   = branch_i;
  assign fifo_addr_o    = branch_addr_i;
  assign fifo_valid_o   = fwd;
  assign fifo_rdata_o   = instr_rdata_i;
  assign fifo_err_o     = instr_err_i;
  assign fifo_align64_o = head.align64;
  assign busy_o         = (count != '0) | instr_req_o;

  // the held request's slot is stale if a branch arrived while it waited
  assign alloc_slot = '{valid: 1'b1, discard: pend_q, align64: align_q};

  always_comb begin
    if (UnalignedFetch) begin
      tgt_addr  = {branch_addr_i[31:2], 2'b00};
      tgt_align = ~branch_addr_i[2];
    end else begin
      tgt_addr  = {branch_addr_i[31:3], 3'b000};
      tgt_align = 1'b1;
    end
  end

  always_comb begin
    addr_d       = addr_q;
    align_d      = align_q;
    err_halt_d   = err_halt_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_align_d = pend_align_q;
    if (fwd & instr_err_i) begin
      err_halt_d = 1'b1;
    end
    if (gnt) begin
      if (pend_q) begin
        addr_d  = pend_addr_q;
        align_d = pend_align_q;
        pend_d  = 1'b0;
      end else begin
        addr_d = addr_q + 32'(FETCH_BYTES);
      end
    end
    if (branch_i) begin
      err_halt_d = 1'b0;
      if (instr_req_o & ~instr_gnt_i) begin
        pend_d       = 1'b1;
        pend_addr_d  = tgt_addr;
        pend_align_d = tgt_align;
      end else begin
        addr_d  = tgt_addr;
        align_d = tgt_align;
        pend_d  = 1'b0;
      end
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      busy_cnt = busy_cnt + SW'(fifo_busy_i[i]);
    end
    cnt_nxt  = SW'(count) + SW'(gnt) - SW'(pop);
    issue_ok = fetch_en_i & ~err_halt_d &
               ((cnt_nxt + busy_cnt) < SW'(NUM_REQS));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue_ok) state_d = REQ;
      REQ:  if (gnt & ~issue_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      align_q      <= 1'b1;
      err_halt_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_align_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      align_q      <= align_d;
      err_halt_q   <= err_halt_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_align_q <= pend_align_d;
    end
  end

  fetch_req_tracker #(
    .NUM_REQS (NUM_REQS)
  ) u_tracker (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (gnt),
    .alloc_slot_i  (alloc_slot),
    .pop_i         (pop),
    .discard_all_i (branch_i),
    .head_o        (head),
    .count_o       (count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(instr_rvalid_i && !head.valid));
    end
  end

endmodule

// File: tb/tb_fetch_req64.sv
// Bench for fetch_req64: bus responder, scoreboard and
// branch-target vector table.
module tb_fetch_req64;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fetch_en_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic [1:0]  fifo_busy_i;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [63:0] instr_rdata_i;
  logic        instr_err_i;

  logic        fifo_clear_o, fifo_valid_o, fifo_err_o, fifo_align64_o;
  logic [31:0] fifo_addr_o, instr_addr_o;
  logic [63:0] fifo_rdata_o;
  logic        instr_req_o, busy_o;

  logic        z_clear, z_valid, z_err, z_align, z_req, z_busy;
  logic [31:0] z_faddr, z_iaddr;
  logic [63:0] z_rdata;

  always #5 clk = ~clk;

  fetch_req64 #(.NUM_REQS(2), .UnalignedFetch(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .fetch_en_i(fetch_en_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .fifo_busy_i(fifo_busy_i), .fifo_clear_o(fifo_clear_o),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o),
    .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o),
    .fifo_align64_o(fifo_align64_o), .instr_req_o(instr_req_o),
    .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .busy_o(busy_o)
  );

  fetch_req64 #(.NUM_REQS(2), .UnalignedFetch(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .fetch_en_i(fetch_en_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .fifo_busy_i(fifo_busy_i), .fifo_clear_o(z_clear),
    .fifo_valid_o(z_valid), .fifo_addr_o(z_faddr),
    .fifo_rdata_o(z_rdata), .fifo_err_o(z_err),
    .fifo_align64_o(z_align), .instr_req_o(z_req),
    .instr_gnt_i(instr_gnt_i), .instr_addr_o(z_iaddr),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .busy_o(z_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] ra_q[$];
  bit          rd_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] gnt0_log[$];
  logic [31:0] fwd_log[$];

  bit          rsp_hold;
  bit          pend_disc;
  bit          prev_wait;
  logic [31:0] prev_addr;
  logic [31:0] err_addr;
  bit          exp_align;
  bit          err_seen;
  int          post_err_gnts;
  int          n_req_cyc;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] a0;
    logic [31:0] a1;
    bit          al;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] at(ref logic [31:0] q[$], input int k);
    return (q.size() > k) ? q[k] : 32'hDEAD_BEEF;
  endfunction

  // one clock: drive bus response, check outputs, update model
  task automatic cyc();
    logic [31:0] a;
    bit          d;
    bit          fwd_exp;
    bit          err_now;
    err_now = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    if (!rsp_hold && ra_q.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = {~ra_q[0], ra_q[0]};
      instr_err_i    = (ra_q[0] == err_addr);
    end
    #1;
    if (instr_req_o) n_req_cyc++;
    if (prev_wait) begin
      chk("req_held", instr_req_o, 1'b1);
      chk("addr_held", instr_addr_o, prev_addr);
    end
    if (branch_i) begin
      chk("clear", fifo_clear_o, 1'b1);
      chk("clear_addr", fifo_addr_o, branch_addr_i);
    end
    if (instr_rvalid_i) begin
      a = ra_q.pop_front();
      d = rd_q.pop_front();
      fwd_exp = !d && !branch_i;
      chk("fwd_valid", fifo_valid_o, fwd_exp);
      if (fwd_exp) begin
        chk("fwd_rdata", fifo_rdata_o, {~a, a});
        chk("fwd_err", fifo_err_o, (a == err_addr));
        chk("fwd_align", fifo_align64_o, exp_align);
        fwd_log.push_back(a);
        if (a == err_addr) err_now = 1'b1;
      end
      if (z_valid) chk("z_align", z_align, 1'b1);
    end
    if (branch_i) begin
      foreach (rd_q[i]) rd_q[i] = 1'b1;
    end
    if (instr_req_o && instr_gnt_i) begin
      ra_q.push_back(instr_addr_o);
      rd_q.push_back(branch_i | pend_disc);
      pend_disc = 1'b0;
      gnt_log.push_back(instr_addr_o);
      if (err_seen) post_err_gnts++;
    end else if (branch_i && instr_req_o) begin
      pend_disc = 1'b1;
    end
    if (z_req && instr_gnt_i) gnt0_log.push_back(z_iaddr);
    prev_wait = instr_req_o && !instr_gnt_i;
    prev_addr = instr_addr_o;
    if (err_now) err_seen = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic branch_to(logic [31:0] t);
    branch_i = 1'b1;
    branch_addr_i = t;
    fetch_en_i = 1'b1;
    cyc();
    branch_i = 1'b0;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    gnt0_log.delete();
    fwd_log.delete();
  endtask

  task automatic drain();
    fetch_en_i = 1'b0;
    instr_gnt_i = 1'b1;
    rsp_hold = 1'b0;
    fifo_busy_i = 2'b00;
    for (int i = 0; i < 40; i++) begin
      if (!busy_o && ra_q.size() == 0) break;
      cyc();
    end
    chk("drain_idle", {busy_o, 31'(ra_q.size())}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1008, 1'b1};
    vecs[1] = '{32'h0000_2006, 32'h0000_2004, 32'h0000_200C, 1'b0};
    vecs[2] = '{32'h0000_200A, 32'h0000_2008, 32'h0000_2010, 1'b1};
    vecs[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0004, 1'b0};

    rst_i = 1'b1;
    fetch_en_i = 1'b0;
    branch_i = 1'b0;
    branch_addr_i = '0;
    fifo_busy_i = 2'b00;
    instr_gnt_i = 1'b1;
    instr_rvalid_i = 1'b0;
    instr_rdata_i = '0;
    instr_err_i = 1'b0;
    rsp_hold = 1'b0;
    pend_disc = 1'b0;
    prev_wait = 1'b0;
    prev_addr = '0;
    err_addr = 32'h0000_0001;
    exp_align = 1'b1;
    err_seen = 1'b0;
    post_err_gnts = 0;
    n_req_cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", instr_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", fifo_valid_o, 1'b0);
    rst_i = 1'b0;

    // branch-target table, gnt always high
    foreach (vecs[v]) begin
      clear_logs();
      exp_align = vecs[v].al;
      instr_gnt_i = 1'b1;
      branch_to(vecs[v].tgt);
      run(6);
      drain();
      chk("v_gnt0", at(gnt_log, 0), vecs[v].a0);
      chk("v_gnt1", at(gnt_log, 1), vecs[v].a1);
      chk("v_fwd0", at(fwd_log, 0), vecs[v].a0);
      chk("v_fwd1", at(fwd_log, 1), vecs[v].a1);
      chk("v_z_gnt0", at(gnt0_log, 0), vecs[v].tgt & 32'hFFFF_FFF8);
    end

    // grant withheld, branch while waiting
    clear_logs();
    exp_align = 1'b1;
    instr_gnt_i = 1'b0;
    branch_to(32'h0000_5000);
    cyc();
    branch_to(32'h0000_3000);
    fetch_en_i = 1'b1;
    cyc();
    instr_gnt_i = 1'b1;
    run(4);
    drain();
    chk("w_gnt0", at(gnt_log, 0), 32'h0000_5000);
    chk("w_gnt1", at(gnt_log, 1), 32'h0000_3000);
    chk("w_fwd0", at(fwd_log, 0), 32'h0000_3000);

    // two outstanding, branch, late responses dropped
    clear_logs();
    rsp_hold = 1'b1;
    branch_to(32'h0000_6000);
    run(4);
    chk("o_two", gnt_log.size(), 2);
    branch_to(32'h0000_7000);
    rsp_hold = 1'b0;
    run(6);
    drain();
    chk("o_fwd0", at(fwd_log, 0), 32'h0000_7000);

    // fifo busy throttling
    clear_logs();
    fifo_busy_i = 2'b11;
    n_req_cyc = 0;
    branch_to(32'h0000_8000);
    run(5);
    chk("b_noreq", n_req_cyc, 0);
    fifo_busy_i = 2'b01;
    rsp_hold = 1'b1;
    run(6);
    chk("b_one", gnt_log.size(), 1);
    drain();

    // error response halts issue until next branch
    clear_logs();
    err_addr = 32'h0000_4008;
    err_seen = 1'b0;
    post_err_gnts = 0;
    branch_to(32'h0000_4000);
    run(10);
    chk("e_seen", err_seen, 1'b1);
    chk("e_halt", post_err_gnts, 0);
    chk("e_busy", busy_o, 1'b0);
    err_addr = 32'h0000_0001;
    err_seen = 1'b0;
    clear_logs();
    branch_to(32'h0000_9000);
    run(3);
    drain();
    chk("e_resume", at(gnt_log, 0), 32'h0000_9000);

    // reset while requests are outstanding
    rsp_hold = 1'b1;
    branch_to(32'h0000_A000);
    run(3);
    rst_i = 1'b1;
    fetch_en_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    ra_q.delete();
    rd_q.delete();
    pend_disc = 1'b0;
    prev_wait = 1'b0;
    rsp_hold = 1'b0;
    chk("r_busy", busy_o, 1'b0);
    chk("r_req", instr_req_o, 1'b0);
    clear_logs();
    fetch_en_i = 1'b1;
    instr_gnt_i = 1'b0;
    cyc();
    chk("r_addr0", {instr_req_o, instr_addr_o}, {1'b1, 32'h0});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
